// File: rtl/bram_vid_pkg.sv
// Shared types and constants for the framebuffer scan-address path.
// Frame geometry values are defaults; the helpers give per-instance values.
package bram_vid_pkg;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        VBLANK  = 2'd1,
        ACTIVE  = 2'd2,
        HBLANK  = 2'd3
    } scan_state_t;

    localparam int HSIZE_DEF    = 640;
    localparam int VSIZE_DEF    = 480;
    localparam int FRAME_PIX    = HSIZE_DEF * VSIZE_DEF;
    localparam int LAST_ROW_OFF = (VSIZE_DEF - 1) * HSIZE_DEF;

    // Sync level meaning "active" for the common active-low timing generators.
    localparam bit SYNC_ACTIVE_LOW = 1'b0;

    function automatic int last_row_off(input int hsize, input int vsize);
        return (vsize - 1) * hsize;
    endfunction

    function automatic logic sync_active(input logic level, input logic pol);
        return level == pol;
    endfunction

endpackage

// File: rtl/vid_sync_edge.sv
// Registers VSYNC/HSYNC/DE once, normalises sync polarity to active-high,
// and derives frame-start and DE-rise events from the registered copies.
module vid_sync_edge
    import bram_vid_pkg::*;
#(
    parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic VSYNC,
    input  logic HSYNC,
    input  logic DE,
    output logic vs_act,
    output logic hs_act,
    output logic de_lvl,
    output logic frame_start,
    output logic de_rise
);

    logic s_vs, s_hs, s_de;
    logic d_vs, d_de;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s_vs <= 1'b0;
            s_hs <= 1'b0;
            s_de <= 1'b0;
            d_vs <= 1'b0;
            d_de <= 1'b0;
        end else begin
            s_vs <= sync_active(VSYNC, SYNC_POL);
            s_hs <= sync_active(HSYNC, SYNC_POL);
            s_de <= DE;
            d_vs <= s_vs;
            d_de <= s_de;
        end
    end

    assign vs_act      = s_vs;
    assign hs_act      = s_hs;
    assign de_lvl      = s_de;
    // Frame starts when VSYNC leaves its active level.
    assign frame_start = d_vs & ~s_vs;
    assign de_rise     = s_de & ~d_de;

endmodule

// File: rtl/bram_scan_addr_gen.sv
// Framebuffer read-address generator: sync/DE in, mirrored linear BRAM
// address out, with frame-latched modes and sticky overrun detection.
module bram_scan_addr_gen
    import bram_vid_pkg::*;
#(
    parameter int HSIZE    = 640,
    parameter int VSIZE    = 480,
    parameter int ADDR_W   = 19,
    parameter int SYNC_POL = 0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              VSYNC,
    input  logic              HSYNC,
    input  logic              DE,
    input  logic              FLIP_H,
    input  logic              FLIP_V,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    output logic              BRAM_EN,
    output logic [13:0]       PIX_X,
    output logic [13:0]       PIX_Y,
    output logic              FRAME_START,
    output logic              ERR_OVR
);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(HSIZE);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(last_row_off(HSIZE, VSIZE));
    localparam logic [13:0]       H_END    = 14'(HSIZE);
    localparam logic [13:0]       H_LAST   = 14'(HSIZE - 1);
    localparam logic [13:0]       V_END    = 14'(VSIZE);

    logic vs_act, hs_act, de_lvl, frame_start, de_rise;

    vid_sync_edge #(.SYNC_POL(SYNC_POL != 0)) u_sync (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .VSYNC       (VSYNC),
        .HSYNC       (HSYNC),
        .DE          (DE),
        .vs_act      (vs_act),
        .hs_act      (hs_act),
        .de_lvl      (de_lvl),
        .frame_start (frame_start),
        .de_rise     (de_rise)
    );

    scan_state_t       state, state_nxt;
    logic              flip_h_q, flip_v_q;
    logic [ADDR_W-1:0] base_q, row_off;
    logic [13:0]       pix_x, pix_y;
    logic              rd, line_end, set_err;
    logic [ADDR_W-1:0] col, rd_addr;

    always_comb begin
        state_nxt = state;
        rd        = 1'b0;
        line_end  = 1'b0;
        set_err   = 1'b0;
        if (frame_start) begin
            state_nxt = VBLANK;
        end else begin
            case (state)
                VBLANK, HBLANK: begin
                    if (de_rise) begin
                        if (pix_y == V_END) begin
                            set_err = 1'b1;
                        end else begin
                            state_nxt = ACTIVE;
                            rd        = 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (vs_act) begin
                        state_nxt = WAIT_VS;
                        set_err   = 1'b1;
                    end else if (hs_act || !de_lvl) begin
                        // HSYNC inside active video closes the line early.
                        state_nxt = HBLANK;
                        line_end  = 1'b1;
                        set_err   = hs_act;
                    end else if (pix_x == H_END) begin
                        set_err = 1'b1;
                    end else begin
                        rd = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign col     = flip_h_q ? ADDR_W'(H_LAST - pix_x) : ADDR_W'(pix_x);
    assign rd_addr = base_q + row_off + col;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= WAIT_VS;
            flip_h_q    <= 1'b0;
            flip_v_q    <= 1'b0;
            base_q      <= '0;
            row_off     <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            ERR_OVR     <= 1'b0;
            FRAME_START <= 1'b0;
            BRAM_EN     <= 1'b0;
            BRAM_ADDR   <= '0;
        end else begin
            state       <= state_nxt;
            FRAME_START <= frame_start;
            BRAM_EN     <= rd;
            if (rd)
                BRAM_ADDR <= rd_addr;
            if (frame_start) begin
                flip_h_q <= FLIP_H;
                flip_v_q <= FLIP_V;
                base_q   <= BASE_ADDR;
                row_off  <= FLIP_V ? ROW_LAST : '0;
                pix_x    <= '0;
                pix_y    <= '0;
                ERR_OVR  <= 1'b0;
            end else begin
                if (set_err)
                    ERR_OVR <= 1'b1;
                if (rd)
                    pix_x <= pix_x + 14'd1;
                if (line_end) begin
                    pix_x   <= '0;
                    pix_y   <= pix_y + 14'd1;
                    row_off <= flip_v_q ? row_off - ROW_STEP : row_off + ROW_STEP;
                end
            end
        end
    end

    assign PIX_X = pix_x;
    assign PIX_Y = pix_y;

endmodule
